// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the synchronous FIFO and its RAM.
// Flag encoding is computed from an occupancy value so reset and run-time use the same rules.
package fifo_pkg;

   localparam int FIFO_DATA_WIDTH = 8;
   localparam int FIFO_ADDR_WIDTH = 4;

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
   } fifo_flags_t;

   function automatic int fifo_depth(input int addr_width);
      return 1 << addr_width;
   endfunction

   function automatic fifo_flags_t fifo_calc_flags(input int cnt, input int depth,
                                                   input int af_level, input int ae_level);
      fifo_flags_t f;
      f.full         = (cnt == depth);
      f.empty        = (cnt == 0);
      f.almost_full  = (cnt >= af_level);
      f.almost_empty = (cnt <= ae_level);
      return f;
   endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer-facing signal bundle of sync_fifo.
// master = the client driving requests, slave = the FIFO itself.
interface sync_fifo_if
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) ();

   logic                  wr_en;
   logic [DATA_WIDTH-1:0] din;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] dout;
   logic                  dout_valid;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [ADDR_WIDTH:0]   count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output wr_en, din, rd_en,
      input  dout, dout_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  wr_en, din, rd_en,
      output dout, dout_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

endinterface

// File: rtl/fifo_ram.sv
// Single-clock simple dual-port RAM: one write port, one registered read port.
// rdata clears on rst; the array itself keeps its contents.
module fifo_ram
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int DEPTH = fifo_depth(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   // NOTE: the array has no reset so it maps onto RAM macros; a reset loop would force it into flops.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem[raddr];
      end
   end

   // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy, registered flags and dout_valid around fifo_ram.
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow logic; otherwise both read 0.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
   parameter int AF_LEVEL   = fifo_depth(ADDR_WIDTH) - 2,
   parameter int AE_LEVEL   = 2
) (
   input  logic       clk,
   input  logic       rst,
   sync_fifo_if.slave bus
);

   localparam int DEPTH = fifo_depth(ADDR_WIDTH);

   typedef logic [ADDR_WIDTH:0] ptr_t;
   localparam ptr_t PTR_ONE = ptr_t'(1);

   ptr_t        wr_ptr_q, wr_ptr_d;
   ptr_t        rd_ptr_q, rd_ptr_d;
   ptr_t        count_q,  count_d;
   fifo_flags_t flags_q,  flags_d;
   logic        dout_valid_q, dout_valid_d;
   logic        wr_acc, rd_acc;

   // NOTE: every always_comb output gets a default first, otherwise an uncovered path infers a latch.
   always_comb begin
      wr_acc       = bus.wr_en && !flags_q.full;
      rd_acc       = bus.rd_en && !flags_q.empty;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      dout_valid_d = rd_acc;

      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;

      unique case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + PTR_ONE;
         2'b01:   count_d = count_q - PTR_ONE;
         default: count_d = count_q;
      endcase

      // Flags come from the next count so they line up with the registered count.
      flags_d = fifo_calc_flags(int'(count_d), DEPTH, AF_LEVEL, AE_LEVEL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         flags_q      <= fifo_calc_flags(0, DEPTH, AF_LEVEL, AE_LEVEL);
         dout_valid_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         flags_q      <= flags_d;
         dout_valid_q <= dout_valid_d;
      end
   end

   fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_acc && !rst),
      .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
      .wdata (bus.din),
      .re    (rd_acc),
      .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
      .rdata (bus.dout)
   );

`ifdef FIFO_ERR_FLAGS_EN
   logic overflow_q,  overflow_d;
   logic underflow_q, underflow_d;

   always_comb begin
      overflow_d  = overflow_q  || (bus.wr_en && flags_q.full);
      underflow_d = underflow_q || (bus.rd_en && flags_q.empty);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
`else
   assign bus.overflow  = 1'b0;
   assign bus.underflow = 1'b0;
`endif

   assign bus.count        = count_q;
   assign bus.full         = flags_q.full;
   assign bus.empty        = flags_q.empty;
   assign bus.almost_full  = flags_q.almost_full;
   assign bus.almost_empty = flags_q.almost_empty;
   assign bus.dout_valid   = dout_valid_q;

endmodule
